// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame parser: FSM encodings and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Parser states, in frame order; DRAIN is the only state that presents bytes.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // Default start-of-frame marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 registers, synchronous write, combinational read.
// Latency: write visible to the read port the cycle after wr_en; read is same-cycle.
// Backpressure: none; the owner sequences writes and reads. Contents are not reset.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Single write port; no reset so the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC, LEN, payload, CHK frames from a UART byte strobe and replays verified payload.
// Latency: first payload byte is valid the cycle after the CHK byte strobe; one byte per accepted beat.
// Backpressure: valid/ready on the payload side; bytes arriving while draining are dropped and flagged.
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Rx_Done,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Frame_Valid,
    input  logic       i_Frame_Ready,
    output logic [7:0] o_Frame_Byte,
    output logic       o_Frame_Last,
    output logic [4:0] o_Frame_Len,
    output logic       o_Len_Err,
    output logic       o_Crc_Err,
    output logic       o_Timeout_Err,
    output logic       o_Overrun_Err
);

    localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [4:0]    len;
    logic [4:0]    idx;
    logic [4:0]    rd_idx;
    logic [7:0]    sum;
    logic [TW-1:0] tmo_cnt;
    logic          len_err;
    logic          crc_err;
    logic          timeout_err;
    logic          overrun_err;

    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic [7:0]    chk_sum;
    logic          last_beat;
    logic          in_frame;

    assign buf_we    = (state == ST_PAYLOAD) && i_Rx_Done;
    assign chk_sum   = sum + i_Rx_Byte;
    assign last_beat = (rd_idx == (len - 5'd1));
    assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (idx[AW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (buf_rdata)
    );

    // Frame FSM with its counters, checksum and one-cycle error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            len         <= '0;
            idx         <= '0;
            rd_idx      <= '0;
            sum         <= '0;
            tmo_cnt     <= '0;
            len_err     <= 1'b0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            len_err     <= 1'b0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;

            // Inter-byte watchdog only runs while a frame is being received.
            if (in_frame) begin
                if (i_Rx_Done) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt     <= '0;
                    timeout_err <= 1'b1;
                    state       <= ST_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (i_Rx_Done && (i_Rx_Byte == SYNC_BYTE)) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_Rx_Done) begin
                        if ((i_Rx_Byte != 8'd0) && (i_Rx_Byte <= MAX_LEN_B)) begin
                            len   <= i_Rx_Byte[4:0];
                            sum   <= i_Rx_Byte;
                            idx   <= '0;
                            state <= ST_PAYLOAD;
                        end else begin
                            len_err <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_Rx_Done) begin
                        sum <= chk_sum;
                        idx <= idx + 5'd1;
                        if (idx == (len - 5'd1)) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_Rx_Done) begin
                        if (chk_sum == 8'd0) begin
                            rd_idx <= '0;
                            state  <= ST_DRAIN;
                        end else begin
                            crc_err <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A byte landing here has nowhere to go; flag it, drain continues.
                    if (i_Rx_Done) begin
                        overrun_err <= 1'b1;
                    end
                    if (i_Frame_Ready) begin
                        if (last_beat) begin
                            rd_idx <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            rd_idx <= rd_idx + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_Frame_Valid = (state == ST_DRAIN);
    assign o_Frame_Byte  = o_Frame_Valid ? buf_rdata : 8'h00;
    assign o_Frame_Last  = o_Frame_Valid && last_beat;
    assign o_Frame_Len   = o_Frame_Valid ? len : 5'd0;
    assign o_Len_Err     = len_err;
    assign o_Crc_Err     = crc_err;
    assign o_Timeout_Err = timeout_err;
    assign o_Overrun_Err = overrun_err;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: table of frames plus hand-written corner sequences.
// Expected payload beats are queued at stimulus time and popped when the DUT transfers a beat.
// Error pulses are counted per case and compared against the expected count for that case.
module tb_uart_rx_frame_parser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ready = 1'b1;
    logic       frame_valid;
    logic [7:0] frame_byte;
    logic       frame_last;
    logic [4:0] frame_len;
    logic       len_err;
    logic       crc_err;
    logic       timeout_err;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;
    int cnt_len = 0;
    int cnt_crc = 0;
    int cnt_to  = 0;
    int cnt_ovr = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [4:0] len;
    } beat_t;

    beat_t exp_q[$];

    typedef struct packed {
        logic [63:0] bytes;  // byte k at [63-8k -: 8]
        logic [3:0]  n;
        logic [31:0] pay;    // expected beat j at [31-8j -: 8]
        logic [2:0]  npay;
        logic [4:0]  len;
        logic        el;
        logic        ec;
    } vec_t;

    vec_t vecs[8];

    uart_rx_frame_parser #(
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_Rx_Done     (rx_done),
        .i_Rx_Byte     (rx_byte),
        .o_Frame_Valid (frame_valid),
        .i_Frame_Ready (ready),
        .o_Frame_Byte  (frame_byte),
        .o_Frame_Last  (frame_last),
        .o_Frame_Len   (frame_len),
        .o_Len_Err     (len_err),
        .o_Crc_Err     (crc_err),
        .o_Timeout_Err (timeout_err),
        .o_Overrun_Err (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        repeat (gap) @(posedge clk);
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l, input logic [4:0] n);
        beat_t b;
        b.data = d;
        b.last = l;
        b.len  = n;
        exp_q.push_back(b);
    endtask

    task automatic reset_counts();
        cnt_len = 0;
        cnt_crc = 0;
        cnt_to  = 0;
        cnt_ovr = 0;
    endtask

    task automatic check_counts(input string name, input int el, input int ec, input int et, input int eo);
        check({name, " len_err"}, 32'(cnt_len), 32'(el));
        check({name, " crc_err"}, 32'(cnt_crc), 32'(ec));
        check({name, " timeout_err"}, 32'(cnt_to), 32'(et));
        check({name, " overrun_err"}, 32'(cnt_ovr), 32'(eo));
        check({name, " pending_beats"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: error pulse counting, beat scoreboard, stall stability, zero-when-idle.
    initial begin
        beat_t cur;
        beat_t prev;
        beat_t e;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (len_err)     cnt_len++;
                if (crc_err)     cnt_crc++;
                if (timeout_err) cnt_to++;
                if (overrun_err) cnt_ovr++;
                if (frame_valid) begin
                    cur.data = frame_byte;
                    cur.last = frame_last;
                    cur.len  = frame_len;
                    if (prev_stall) check("stall_hold", 32'(cur), 32'(prev));
                    if (ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got byte %0h last %0b len %0d, expected no beat",
                                     frame_byte, frame_last, frame_len);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", 32'(cur), 32'(e));
                        end
                    end
                    prev_stall = !ready;
                    prev = cur;
                end else begin
                    check("idle_zero", {18'd0, frame_byte, frame_last, frame_len}, 32'd0);
                    prev_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        vecs[0] = '{64'hA503112233970000, 4'd6, 32'h11223300, 3'd3, 5'd3, 1'b0, 1'b0};
        vecs[1] = '{64'hA503112233980000, 4'd6, 32'h00000000, 3'd0, 5'd0, 1'b0, 1'b1};
        vecs[2] = '{64'hA500000000000000, 4'd2, 32'h00000000, 3'd0, 5'd0, 1'b1, 1'b0};
        vecs[3] = '{64'hA511000000000000, 4'd2, 32'h00000000, 3'd0, 5'd0, 1'b1, 1'b0};
        vecs[4] = '{64'h1234A5017E810000, 4'd6, 32'h7E000000, 3'd1, 5'd1, 1'b0, 1'b0};
        vecs[5] = '{64'hA502A5A5B4000000, 4'd5, 32'hA5A50000, 3'd2, 5'd2, 1'b0, 1'b0};
        vecs[6] = '{64'hA5A5000000000000, 4'd2, 32'h00000000, 3'd0, 5'd0, 1'b1, 1'b0};
        vecs[7] = '{64'hA50100FF00000000, 4'd4, 32'h00000000, 3'd1, 5'd1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {13'd0, frame_valid, frame_byte, frame_last, frame_len,
               len_err, crc_err, timeout_err, overrun_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven frames, consumer always ready
        for (int i = 0; i < 8; i++) begin
            reset_counts();
            for (int j = 0; j < int'(vecs[i].npay); j++) begin
                push_beat(vecs[i].pay[31-8*j -: 8], (j == int'(vecs[i].npay) - 1), vecs[i].len);
            end
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                send_byte(vecs[i].bytes[63-8*k -: 8], 2);
            end
            repeat (10) @(posedge clk);
            check_counts($sformatf("vec%0d", i), int'(vecs[i].el), int'(vecs[i].ec), 0, 0);
        end

        // Maximum length frame: 16 bytes 01..10, checksum 68
        reset_counts();
        for (int j = 0; j < 16; j++) push_beat(8'(j + 1), (j == 15), 5'd16);
        send_byte(8'hA5, 1);
        send_byte(8'h10, 1);
        for (int j = 0; j < 16; j++) send_byte(8'(j + 1), 1);
        send_byte(8'h68, 1);
        repeat (25) @(posedge clk);
        check_counts("max_len", 0, 0, 0, 0);

        // Inter-byte timeout, then recovery with a good frame
        reset_counts();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        repeat (990) @(posedge clk);
        check("timeout_early", 32'(cnt_to), 32'd0);
        repeat (20) @(posedge clk);
        check_counts("timeout", 0, 0, 1, 0);
        reset_counts();
        push_beat(8'h11, 1'b0, 5'd3);
        push_beat(8'h22, 1'b0, 5'd3);
        push_beat(8'h33, 1'b1, 5'd3);
        send_byte(8'hA5, 2);
        send_byte(8'h03, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        send_byte(8'h97, 2);
        repeat (10) @(posedge clk);
        check_counts("after_timeout", 0, 0, 0, 0);

        // Backpressure during drain with a byte arriving mid-drain
        reset_counts();
        ready = 1'b0;
        push_beat(8'h11, 1'b0, 5'd3);
        push_beat(8'h22, 1'b0, 5'd3);
        push_beat(8'h33, 1'b1, 5'd3);
        send_byte(8'hA5, 1);
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h97, 0);
        send_byte(8'h55, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_valid", 32'(frame_valid), 32'd1);
        check("stall_byte", 32'(frame_byte), 32'h11);
        check("stall_len", 32'(frame_len), 32'd3);
        ready = 1'b1;
        repeat (10) @(posedge clk);
        check_counts("overrun", 0, 0, 0, 1);

        // Byte strobe (sync value) coinciding with the final drain transfer
        reset_counts();
        push_beat(8'h7E, 1'b1, 5'd1);
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h7E, 1);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_byte = 8'h81;
        @(posedge clk);
        #1;
        rx_byte = 8'hA5;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        send_byte(8'h01, 1);
        send_byte(8'h7E, 1);
        send_byte(8'h81, 1);
        repeat (10) @(posedge clk);
        check_counts("last_overrun", 0, 0, 0, 1);

        // Reset mid-frame, then a single-byte frame
        reset_counts();
        send_byte(8'hA5, 1);
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              {13'd0, frame_valid, frame_byte, frame_last, frame_len,
               len_err, crc_err, timeout_err, overrun_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_beat(8'h7E, 1'b1, 5'd1);
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h7E, 2);
        send_byte(8'h81, 2);
        repeat (10) @(posedge clk);
        check_counts("after_reset", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
